// File: rtl/frame_draw_scheduler_if.sv
// Frame-tick, game-state inputs and the shared vga_adapter write port, plus frame status.
// The master side belongs to the draw scheduler. The slave side belongs to its surroundings.
interface frame_draw_scheduler_if #(
    parameter int NUM_COLS = 40
);
    logic                frame_tick;
    logic                clear_req;
    logic [NUM_COLS-1:0] obstacle_data;
    logic [6:0]          bird_y;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [2:0]          colour;
    logic                plot;
    logic                shift_en;
    logic                busy;
    logic                frame_done;
    logic                overrun;

    modport master (
        input  frame_tick, clear_req, obstacle_data, bird_y,
        output x, y, colour, plot, shift_en, busy, frame_done, overrun
    );

    modport slave (
        output frame_tick, clear_req, obstacle_data, bird_y,
        input  x, y, colour, plot, shift_en, busy, frame_done, overrun
    );
endinterface

// File: rtl/frame_draw_scheduler.sv
// Per-frame draw sequencer: owns the VGA write port and emits one pixel per cycle.
// Draw order is clear, floor, ceiling, obstacles, bird erase, bird draw, then shift pulse.
module frame_draw_scheduler #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int FLOOR_Y  = 110,
    parameter int CEIL_Y   = 10,
    parameter int OBST_X0  = 156,
    parameter int OBST_Y   = 40,
    parameter int BIRD_X   = 20,
    parameter int NUM_COLS = 40
) (
    input logic                   clk,
    input logic                   resetn,
    frame_draw_scheduler_if.master bus
);
    localparam int         KW         = $clog2(NUM_COLS);
    localparam logic [7:0] LAST_X     = 8'(SCREEN_W - 1);
    localparam logic [6:0] LAST_Y     = 7'(SCREEN_H - 1);
    localparam logic [6:0] BIRD_MAX_Y = 7'(SCREEN_H - 4);
    localparam logic [6:0] FLOOR_Y7   = 7'(FLOOR_Y);
    localparam logic [6:0] CEIL_Y7    = 7'(CEIL_Y);
    localparam logic [7:0] OBST_X0_8  = 8'(OBST_X0);
    localparam logic [6:0] OBST_Y7    = 7'(OBST_Y);
    localparam logic [7:0] BIRD_X8    = 8'(BIRD_X);
    localparam logic [KW-1:0] LAST_K  = KW'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FLOOR, S_CEIL, S_OBST, S_BIRD_ERASE, S_BIRD_DRAW, S_ADVANCE
    } state_t;

    state_t        state_reg;
    logic [7:0]    cx_reg;
    logic [6:0]    cy_reg;
    logic [KW-1:0] k_reg;
    logic [3:0]    cnt_reg;
    logic          clear_pending_reg;
    logic [6:0]    bird_cur_y_reg;
    logic [6:0]    bird_prev_y_reg;
    logic [7:0]    x_reg;
    logic [6:0]    y_reg;
    logic [2:0]    colour_reg;
    logic          plot_reg;
    logic          shift_en_reg;
    logic          busy_reg;
    logic          frame_done_reg;
    logic          overrun_reg;

    assign bus.x          = x_reg;
    assign bus.y          = y_reg;
    assign bus.colour     = colour_reg;
    assign bus.plot       = plot_reg;
    assign bus.shift_en   = shift_en_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.overrun    = overrun_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= S_IDLE;
            cx_reg            <= '0;
            cy_reg            <= '0;
            k_reg             <= '0;
            cnt_reg           <= '0;
            clear_pending_reg <= 1'b1;
            bird_cur_y_reg    <= '0;
            bird_prev_y_reg   <= '0;
            x_reg             <= '0;
            y_reg             <= '0;
            colour_reg        <= '0;
            plot_reg          <= 1'b0;
            shift_en_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            frame_done_reg    <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            plot_reg       <= 1'b0;
            shift_en_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            // busy stays high through the cycle after ADVANCE, so ticks there are dropped too
            overrun_reg    <= bus.frame_tick & busy_reg;

            case (state_reg)
                S_IDLE: begin
                    busy_reg <= 1'b0;
                    if (bus.frame_tick && !busy_reg) begin
                        busy_reg       <= 1'b1;
                        bird_cur_y_reg <= (bus.bird_y > BIRD_MAX_Y) ? BIRD_MAX_Y : bus.bird_y;
                        state_reg      <= (clear_pending_reg || bus.clear_req) ? S_CLEAR : S_FLOOR;
                    end
                end
                S_CLEAR: begin
                    x_reg      <= cx_reg;
                    y_reg      <= cy_reg;
                    colour_reg <= 3'b000;
                    plot_reg   <= 1'b1;
                    if (cx_reg == LAST_X) begin
                        cx_reg <= '0;
                        if (cy_reg == LAST_Y) begin
                            cy_reg            <= '0;
                            clear_pending_reg <= 1'b0;
                            state_reg         <= S_FLOOR;
                        end else begin
                            cy_reg <= cy_reg + 7'd1;
                        end
                    end else begin
                        cx_reg <= cx_reg + 8'd1;
                    end
                end
                S_FLOOR, S_CEIL: begin
                    x_reg      <= cx_reg;
                    y_reg      <= (state_reg == S_FLOOR) ? FLOOR_Y7 : CEIL_Y7;
                    colour_reg <= 3'b010;
                    plot_reg   <= 1'b1;
                    if (cx_reg == LAST_X) begin
                        cx_reg    <= '0;
                        state_reg <= (state_reg == S_FLOOR) ? S_CEIL : S_OBST;
                    end else begin
                        cx_reg <= cx_reg + 8'd1;
                    end
                end
                S_OBST: begin
                    // obstacle_data is sampled live so the column reflects the current register
                    x_reg      <= OBST_X0_8 - 8'({k_reg, 2'b00}) + {6'b0, cnt_reg[3:2]};
                    y_reg      <= OBST_Y7 + {5'b0, cnt_reg[1:0]};
                    colour_reg <= bus.obstacle_data[k_reg] ? 3'b011 : 3'b000;
                    plot_reg   <= 1'b1;
                    cnt_reg    <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        if (k_reg == LAST_K) begin
                            k_reg     <= '0;
                            state_reg <= S_BIRD_ERASE;
                        end else begin
                            k_reg <= k_reg + 1'b1;
                        end
                    end
                end
                S_BIRD_ERASE, S_BIRD_DRAW: begin
                    x_reg      <= BIRD_X8 + {6'b0, cnt_reg[3:2]};
                    y_reg      <= ((state_reg == S_BIRD_ERASE) ? bird_prev_y_reg : bird_cur_y_reg)
                                  + {5'b0, cnt_reg[1:0]};
                    colour_reg <= (state_reg == S_BIRD_ERASE) ? 3'b000 : 3'b110;
                    plot_reg   <= 1'b1;
                    cnt_reg    <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
                        if (state_reg == S_BIRD_ERASE) begin
                            state_reg <= S_BIRD_DRAW;
                        end else begin
                            bird_prev_y_reg <= bird_cur_y_reg;
                            state_reg       <= S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    shift_en_reg   <= 1'b1;
                    frame_done_reg <= 1'b1;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase

            // a request landing on the last clear pixel still gets served next frame
            if (bus.clear_req) clear_pending_reg <= 1'b1;
        end
    end
endmodule
